// File: rtl/enemy_controller.sv
// enemy_controller: single-enemy lifecycle FSM (spawn, fall, take hits, die or escape).
// Optional ENEMY_DRIFT_EN adds horizontal bouncing drift between X_MIN and X_MAX.
module enemy_controller #(
    parameter logic [9:0] Y_SPAWN      = 10'd24,
    parameter logic [9:0] Y_LIMIT      = 10'd456,
    parameter int         DYING_FRAMES = 4,
    parameter logic [9:0] X_MIN        = 10'd8,
    parameter logic [9:0] X_MAX        = 10'd631
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       spawn_req,
    input  logic [1:0] spawn_type,
    input  logic [9:0] spawn_x,
    input  logic       hit,
    output logic       spawn_ack,
    output logic       active,
    output logic [1:0] enemy_type,
    output logic [3:0] health,
    output logic [9:0] x_mid,
    output logic [9:0] y_mid,
    output logic       killed,
    output logic       escaped
);
    localparam int DW = $clog2(DYING_FRAMES + 1);

    if (X_MIN >= X_MAX) begin : g_bad_bounds
        $error("X_MIN must be below X_MAX");
    end

    typedef enum logic [1:0] {IDLE, ALIVE, DYING} state_t;

    state_t        state, state_nx;
    logic [1:0]    type_nx;
    logic [3:0]    health_nx;
    logic [9:0]    x_nx, y_nx, y_step, spawn_xc;
    logic          move_q, move_nx, steps;
    logic [DW-1:0] die_q, die_nx;
    logic          ack_nx, killed_nx, escaped_nx;
`ifdef ENEMY_DRIFT_EN
    logic          dir_q, dir_nx;
    logic [9:0]    x_drift;
`endif

    assign active = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            enemy_type <= '0;
            health     <= '0;
            x_mid      <= '0;
            y_mid      <= '0;
            move_q     <= 1'b0;
            die_q      <= '0;
            spawn_ack  <= 1'b0;
            killed     <= 1'b0;
            escaped    <= 1'b0;
`ifdef ENEMY_DRIFT_EN
            dir_q      <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            enemy_type <= type_nx;
            health     <= health_nx;
            x_mid      <= x_nx;
            y_mid      <= y_nx;
            move_q     <= move_nx;
            die_q      <= die_nx;
            spawn_ack  <= ack_nx;
            killed     <= killed_nx;
            escaped    <= escaped_nx;
`ifdef ENEMY_DRIFT_EN
            dir_q      <= dir_nx;
`endif
        end
    end

    always_comb begin
        state_nx   = state;
        type_nx    = enemy_type;
        health_nx  = health;
        x_nx       = x_mid;
        y_nx       = y_mid;
        move_nx    = move_q;
        die_nx     = die_q;
        ack_nx     = 1'b0;
        killed_nx  = 1'b0;
        escaped_nx = 1'b0;
        // type 2 moves only on every second tick, when the toggle is already set
        steps      = frame_tick && (enemy_type != 2'd2 || move_q);
        y_step     = y_mid + (enemy_type == 2'd0 ? 10'd2 : 10'd1);
`ifdef ENEMY_DRIFT_EN
        dir_nx     = dir_q;
        x_drift    = dir_q ? x_mid - 10'd1 : x_mid + 10'd1;
        spawn_xc   = spawn_x < X_MIN ? X_MIN : (spawn_x > X_MAX ? X_MAX : spawn_x);
`else
        spawn_xc   = spawn_x;
`endif
        case (state)
            IDLE: begin
                if (spawn_req && spawn_type != 2'd3) begin
                    state_nx  = ALIVE;
                    ack_nx    = 1'b1;
                    type_nx   = spawn_type;
                    x_nx      = spawn_xc;
                    y_nx      = Y_SPAWN;
                    health_nx = spawn_type == 2'd0 ? 4'd1 : (spawn_type == 2'd1 ? 4'd3 : 4'd4);
                    move_nx   = 1'b0;
`ifdef ENEMY_DRIFT_EN
                    dir_nx    = 1'b0;
`endif
                end
            end
            ALIVE: begin
                if (hit && health <= 4'd1) begin
                    state_nx  = DYING;
                    health_nx = 4'd0;
                    killed_nx = 1'b1;
                    die_nx    = '0;
                end else begin
                    if (hit) health_nx = health - 4'd1;
                    if (frame_tick) move_nx = ~move_q;
                    if (steps) begin
                        y_nx = y_step;
`ifdef ENEMY_DRIFT_EN
                        x_nx   = x_drift >= X_MAX ? X_MAX : (x_drift <= X_MIN ? X_MIN : x_drift);
                        dir_nx = x_drift >= X_MAX ? 1'b1 : (x_drift <= X_MIN ? 1'b0 : dir_q);
`endif
                        if (y_step >= Y_LIMIT) begin
                            state_nx   = IDLE;
                            health_nx  = 4'd0;
                            escaped_nx = 1'b1;
                        end
                    end
                end
            end
            DYING: begin
                if (frame_tick) begin
                    die_nx = die_q + 1'b1;
                    if (die_q == DW'(DYING_FRAMES - 1)) begin
                        state_nx = IDLE;
                        die_nx   = '0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_enemy_controller.sv
// tb_enemy_controller: directed stimulus with a scoreboard queue; a monitor pops and
// compares a full output snapshot on every pulse or requested probe.
module tb_enemy_controller;
`ifdef ENEMY_DRIFT_EN
    localparam int DR = 1;
`else
    localparam int DR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0, spawn_req = 1'b0, hit = 1'b0;
    logic [1:0] spawn_type = '0;
    logic [9:0] spawn_x = '0;
    logic       spawn_ack, active, killed, escaped;
    logic [1:0] enemy_type;
    logic [3:0] health;
    logic [9:0] x_mid, y_mid;
    logic       probe = 1'b0;

    typedef struct {
        string       name;
        logic [29:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails = 0;

    enemy_controller dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .spawn_req(spawn_req),
        .spawn_type(spawn_type), .spawn_x(spawn_x), .hit(hit), .spawn_ack(spawn_ack),
        .active(active), .enemy_type(enemy_type), .health(health), .x_mid(x_mid),
        .y_mid(y_mid), .killed(killed), .escaped(escaped)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] mk(input logic a, input logic k, input logic s, input logic act,
                                       input logic [1:0] t, input logic [3:0] h,
                                       input logic [9:0] x, input logic [9:0] y);
        return {a, k, s, act, t, h, x, y};
    endfunction

    function automatic string fmt(input logic [29:0] v);
        return $sformatf("ack=%b kil=%b esc=%b act=%b type=%0d hp=%0d x=%0d y=%0d",
                         v[29], v[28], v[27], v[26], v[25:24], v[23:20], v[19:10], v[9:0]);
    endfunction

    always @(negedge clk) begin
        if (probe || spawn_ack || killed || escaped) begin
            logic [29:0] got;
            exp_t        e;
            got = {spawn_ack, killed, escaped, active, enemy_type, health, x_mid, y_mid};
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output got %s", fmt(got));
            end else begin
                e = sb.pop_front();
                if (got !== e.v) begin
                    fails++;
                    $display("FAIL %s got %s expected %s", e.name, fmt(got), fmt(e.v));
                end
            end
        end
    end

    task automatic drive(input logic sr, input logic [1:0] st, input logic [9:0] sx,
                         input logic ft, input logic h);
        spawn_req = sr; spawn_type = st; spawn_x = sx; frame_tick = ft; hit = h;
    endtask

    task automatic step(input bit chk, input string nm, input logic [29:0] v);
        if (chk) sb.push_back('{nm, v});
        @(posedge clk);
        #1 probe = chk;
        @(negedge clk);
        #1 probe = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        step(1, "reset_state", mk(0,0,0,0,0,0,0,0));
        rst_n = 1'b1;

        drive(1, 2'd1, 10'd100, 0, 0);
        step(1, "spawn_t1", mk(1,0,0,1,1,3,100,24));
        drive(1, 2'd2, 10'd300, 0, 0);
        step(1, "spawn_while_alive", mk(0,0,0,1,1,3,100,24));
        drive(0, 0, 0, 1, 0);
        step(1, "t1_move", mk(0,0,0,1,1,3,10'(100+DR),25));
        drive(0, 0, 0, 1, 1);
        step(1, "hit_and_move", mk(0,0,0,1,1,2,10'(100+2*DR),26));
        drive(0, 0, 0, 0, 1);
        step(1, "hit_to_1", mk(0,0,0,1,1,1,10'(100+2*DR),26));
        step(1, "kill_t1", mk(0,1,0,1,1,0,10'(100+2*DR),26));
        drive(0, 0, 0, 1, 1);
        step(1, "dying_tick1_hit_ignored", mk(0,0,0,1,1,0,10'(100+2*DR),26));
        drive(0, 0, 0, 1, 0);
        step(1, "dying_tick2", mk(0,0,0,1,1,0,10'(100+2*DR),26));
        step(1, "dying_tick3", mk(0,0,0,1,1,0,10'(100+2*DR),26));
        step(1, "dying_done", mk(0,0,0,0,1,0,10'(100+2*DR),26));

        drive(1, 2'd3, 10'd5, 1, 1);
        step(1, "spawn_type3_ignored", mk(0,0,0,0,1,0,10'(100+2*DR),26));

        drive(1, 2'd2, 10'd200, 0, 0);
        step(1, "spawn_t2", mk(1,0,0,1,2,4,200,24));
        drive(0, 0, 0, 1, 0);
        step(1, "t2_tick1", mk(0,0,0,1,2,4,200,24));
        step(1, "t2_tick2", mk(0,0,0,1,2,4,10'(200+DR),25));
        step(1, "t2_tick3", mk(0,0,0,1,2,4,10'(200+DR),25));
        step(1, "t2_tick4", mk(0,0,0,1,2,4,10'(200+2*DR),26));
        drive(0, 0, 0, 0, 1);
        step(1, "t2_hit1", mk(0,0,0,1,2,3,10'(200+2*DR),26));
        step(0, "", '0);
        step(0, "", '0);
        step(1, "t2_kill", mk(0,1,0,1,2,0,10'(200+2*DR),26));
        drive(0, 0, 0, 1, 0);
        repeat (3) step(0, "", '0);
        step(1, "t2_idle", mk(0,0,0,0,2,0,10'(200+2*DR),26));

        drive(1, 2'd0, 10'd50, 0, 0);
        step(1, "spawn_t0", mk(1,0,0,1,0,1,50,24));
        drive(0, 0, 0, 1, 0);
        step(1, "t0_tick1", mk(0,0,0,1,0,1,10'(50+DR),26));
        step(0, "", '0);
        step(0, "", '0);
        step(1, "t0_tick4", mk(0,0,0,1,0,1,10'(50+4*DR),32));
        repeat (211) step(0, "", '0);
        drive(0, 0, 0, 0, 0);
        step(1, "t0_at_454", mk(0,0,0,1,0,1,10'(50+215*DR),454));
        drive(0, 0, 0, 1, 1);
        step(1, "kill_beats_escape", mk(0,1,0,1,0,0,10'(50+215*DR),454));
        drive(0, 0, 0, 1, 0);
        repeat (4) step(0, "", '0);

        drive(1, 2'd0, 10'd60, 0, 0);
        step(1, "respawn_t0", mk(1,0,0,1,0,1,60,24));
        drive(0, 0, 0, 1, 0);
        repeat (215) step(0, "", '0);
        step(1, "escape", mk(0,0,1,0,0,0,10'(60+216*DR),456));
        step(1, "no_repeat_escape", mk(0,0,0,0,0,0,10'(60+216*DR),456));

        drive(1, 2'd1, 10'd630, 0, 0);
        step(1, "spawn_630", mk(1,0,0,1,1,3,630,24));
        drive(0, 0, 0, 1, 0);
        step(1, "drift_move1", mk(0,0,0,1,1,3,10'(630+DR),25));
        step(1, "drift_move2", mk(0,0,0,1,1,3,10'd630,26));
        drive(0, 0, 0, 0, 1);
        step(0, "", '0);
        step(0, "", '0);
        step(1, "kill_630", mk(0,1,0,1,1,0,630,26));
        drive(0, 0, 0, 1, 0);
        step(1, "dying_before_reset", mk(0,0,0,1,1,0,630,26));
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        step(1, "reset_mid_dying", mk(0,0,0,0,0,0,0,0));
        rst_n = 1'b1;
        drive(1, 2'd2, 10'd77, 0, 0);
        step(1, "spawn_after_reset", mk(1,0,0,1,2,4,77,24));
        drive(0, 0, 0, 0, 0);
        repeat (3) step(0, "", '0);

        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
